ddr_arb_fwft_rr_scheduler: RTL and testbench

Round-robin read scheduler that drains NUM_CH per-requester FWFT FIFOs into one shared valid/ready stream toward the DDR AXI4 write path. Each grant moves exactly BURST_MAX beats from one channel, popping that channel's FWFT FIFO with its active-high read enable. The block sits between the per-port FWFT FIFO instances and the single AXI write-data builder in the DDR arbiter. It owns channel selection, burst sequencing and pop generation.

---
 rtl/ddr_arb_fwft_rr_scheduler.sv | 129 ++++++++++++
 tb/tb_ddr_arb_fwft_rr_scheduler.sv | 358 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ddr_arb_fwft_rr_scheduler.sv
// Round-robin burst scheduler: drains per-requester FWFT FIFOs into one valid/ready
// stream, moving exactly BURST_MAX beats from the granted channel per grant.
module ddr_arb_fwft_rr_scheduler #(
  parameter  int NUM_CH    = 4,
  parameter  int DWIDTH    = 64,
  parameter  int BURST_MAX = 16,
  localparam int CH_W      = $clog2(NUM_CH),
  localparam int CNT_W     = $clog2(BURST_MAX)
) (
  input  logic                     pos_rclk,
  input  logic                     reset_rclk,
  input  logic                     enable,
  input  logic [NUM_CH-1:0]        ch_empty,
  input  logic [NUM_CH-1:0]        ch_burst_rdy,
  input  logic [NUM_CH*DWIDTH-1:0] ch_dout,
  output logic [NUM_CH-1:0]        ch_rd_en,
  output logic                     m_valid,
  input  logic                     m_ready,
  output logic [DWIDTH-1:0]        m_data,
  output logic [CH_W-1:0]          m_id,
  output logic                     m_last,
  output logic                     busy,
  output logic [15:0]              burst_cnt
);

  typedef enum logic {
    IDLE = 1'b0,
    XFER = 1'b1
  } state_t;

  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BURST_MAX - 1);

  state_t            state;
  state_t            state_next;
  logic [CNT_W-1:0]  beat_cnt;
  logic [CH_W-1:0]   last_grant;
  logic [CH_W-1:0]   grant_idx;
  logic              grant_found;
  int                best_dist;
  logic              sel_empty;
  logic [DWIDTH-1:0] sel_data;
  logic              handshake;

  // Round-robin pick: smallest rotational distance from the channel after last_grant.
  always_comb begin
    // NOTE: every variable gets a default before any branch so no latch is inferred.
    best_dist   = NUM_CH;
    grant_idx   = '0;
    grant_found = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (ch_burst_rdy[i] &&
          ((i + NUM_CH - 1 - int'(last_grant)) % NUM_CH) < best_dist) begin
        best_dist   = (i + NUM_CH - 1 - int'(last_grant)) % NUM_CH;
        grant_idx   = CH_W'(i);
        grant_found = 1'b1;
      end
    end
  end

  always_comb begin
    sel_empty = 1'b1;
    sel_data  = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (m_id == CH_W'(i)) begin
        sel_empty = ch_empty[i];
        sel_data  = ch_dout[i*DWIDTH +: DWIDTH];
      end
    end
  end

  always_ff @(posedge pos_rclk or negedge reset_rclk) begin
    if (!reset_rclk) begin
      state <= IDLE;
    end else begin
      // NOTE: registered state uses non-blocking assignments so every flop samples pre-edge values.
      state <= state_next;
    end
  end

  // Outputs decode from registered state only, so async reset clears them immediately.
  always_comb begin
    state_next = state;
    m_valid    = 1'b0;
    m_last     = 1'b0;
    busy       = 1'b0;
    handshake  = 1'b0;
    ch_rd_en   = '0;
    m_data     = sel_data;
    case (state)
      IDLE: begin
        if (enable && grant_found) state_next = XFER;
      end
      XFER: begin
        busy      = 1'b1;
        m_valid   = !sel_empty;
        m_last    = (beat_cnt == LAST_BEAT);
        handshake = m_valid && m_ready;
        for (int i = 0; i < NUM_CH; i++) begin
          ch_rd_en[i] = handshake && (m_id == CH_W'(i));
        end
        if (handshake && m_last) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge pos_rclk or negedge reset_rclk) begin
    if (!reset_rclk) begin
      m_id       <= '0;
      beat_cnt   <= '0;
      burst_cnt  <= '0;
      last_grant <= CH_W'(NUM_CH - 1);
    end else if (state == IDLE) begin
      if (enable && grant_found) begin
        m_id     <= grant_idx;
        beat_cnt <= '0;
      end
    end else if (handshake) begin
      if (m_last) begin
        last_grant <= m_id;
        burst_cnt  <= burst_cnt + 16'd1;
        beat_cnt   <= '0;
      end else begin
        beat_cnt <= beat_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_ddr_arb_fwft_rr_scheduler.sv
// Bench for ddr_arb_fwft_rr_scheduler: queue-backed FWFT FIFO environment plus a
// burst-level reference model compared every cycle, with directed and random scenarios.
module tb_ddr_arb_fwft_rr_scheduler;
  localparam int NUM_CH    = 4;
  localparam int DWIDTH    = 64;
  localparam int BURST_MAX = 4;
  localparam int CH_W      = 2;

  logic                     pos_rclk = 1'b0;
  logic                     reset_rclk;
  logic                     enable;
  logic [NUM_CH-1:0]        ch_empty;
  logic [NUM_CH-1:0]        ch_burst_rdy;
  logic [NUM_CH*DWIDTH-1:0] ch_dout;
  logic [NUM_CH-1:0]        ch_rd_en;
  logic                     m_valid;
  logic                     m_ready;
  logic [DWIDTH-1:0]        m_data;
  logic [CH_W-1:0]          m_id;
  logic                     m_last;
  logic                     busy;
  logic [15:0]              burst_cnt;

  ddr_arb_fwft_rr_scheduler #(
    .NUM_CH   (NUM_CH),
    .DWIDTH   (DWIDTH),
    .BURST_MAX(BURST_MAX)
  ) dut (
    .pos_rclk    (pos_rclk),
    .reset_rclk  (reset_rclk),
    .enable      (enable),
    .ch_empty    (ch_empty),
    .ch_burst_rdy(ch_burst_rdy),
    .ch_dout     (ch_dout),
    .ch_rd_en    (ch_rd_en),
    .m_valid     (m_valid),
    .m_ready     (m_ready),
    .m_data      (m_data),
    .m_id        (m_id),
    .m_last      (m_last),
    .busy        (busy),
    .burst_cnt   (burst_cnt)
  );

  always #5 pos_rclk = ~pos_rclk;

  typedef struct {
    logic [DWIDTH-1:0] data;
    int                id;
    bit                last;
    int                cyc;
  } beat_t;

  logic [DWIDTH-1:0] fifo [NUM_CH][$];
  logic [NUM_CH-1:0] force_empty = '0;
  beat_t             seen[$];
  int                pops [NUM_CH];
  int                cyc    = 0;
  int                passed = 0;
  int                total  = 0;
  int                seq    = 0;

  // Reference model: a burst is "open" on channel mdl_id with mdl_beats accepted so far.
  bit mdl_busy;
  int mdl_id, mdl_last_grant, mdl_beats, mdl_bursts;

  task automatic model_reset();
    mdl_busy       = 1'b0;
    mdl_id         = 0;
    mdl_last_grant = NUM_CH - 1;
    mdl_beats      = 0;
    mdl_bursts     = 0;
  endtask

  task automatic clear_env();
    for (int c = 0; c < NUM_CH; c++) begin
      fifo[c].delete();
      pops[c] = 0;
    end
    seen.delete();
    force_empty = '0;
  endtask

  function automatic int rr_pick(int last, logic [NUM_CH-1:0] rdy);
    int pick;
    pick = -1;
    for (int k = NUM_CH; k >= 1; k--) begin
      if (rdy[(last + k) % NUM_CH]) pick = (last + k) % NUM_CH;
    end
    return pick;
  endfunction

  task automatic refresh();
    for (int c = 0; c < NUM_CH; c++) begin
      ch_empty[c] = (fifo[c].size() == 0) || force_empty[c];
      ch_dout[c*DWIDTH +: DWIDTH] = (fifo[c].size() > 0) ? fifo[c][0] : {$urandom, $urandom};
    end
  endtask

  // One clock: settle inputs, compare DUT to model, then advance FIFOs and model at the edge.
  task automatic tick();
    bit                exp_valid;
    bit                exp_last;
    logic [NUM_CH-1:0] exp_rd;
    logic [NUM_CH-1:0] rd_obs;
    int                nxt;
    refresh();
    #1;
    exp_valid = mdl_busy && (fifo[mdl_id].size() > 0) && !force_empty[mdl_id];
    exp_last  = mdl_busy && (mdl_beats == BURST_MAX - 1);
    exp_rd    = '0;
    if (exp_valid && m_ready) exp_rd[mdl_id] = 1'b1;
    total++; if (busy !== mdl_busy) $display("FAIL busy cyc=%0d got=%b exp=%b", cyc, busy, mdl_busy); else passed++;
    total++; if (m_valid !== exp_valid) $display("FAIL m_valid cyc=%0d got=%b exp=%b", cyc, m_valid, exp_valid); else passed++;
    total++; if (m_last !== exp_last) $display("FAIL m_last cyc=%0d got=%b exp=%b", cyc, m_last, exp_last); else passed++;
    total++; if (ch_rd_en !== exp_rd) $display("FAIL ch_rd_en cyc=%0d got=%b exp=%b", cyc, ch_rd_en, exp_rd); else passed++;
    total++; if (m_id !== CH_W'(mdl_id)) $display("FAIL m_id cyc=%0d got=%0d exp=%0d", cyc, m_id, mdl_id); else passed++;
    total++; if (burst_cnt !== 16'(mdl_bursts)) $display("FAIL burst_cnt cyc=%0d got=%0d exp=%0d", cyc, burst_cnt, mdl_bursts); else passed++;
    if (exp_valid) begin
      total++;
      if (m_data !== fifo[mdl_id][0]) $display("FAIL m_data cyc=%0d got=%h exp=%h", cyc, m_data, fifo[mdl_id][0]);
      else passed++;
    end
    rd_obs = ch_rd_en;
    if (m_valid === 1'b1 && m_ready === 1'b1) seen.push_back('{m_data, int'(m_id), m_last, cyc});
    for (int c = 0; c < NUM_CH; c++) if (rd_obs[c] === 1'b1) pops[c]++;
    @(posedge pos_rclk);
    for (int c = 0; c < NUM_CH; c++) begin
      if (rd_obs[c] === 1'b1 && fifo[c].size() > 0) void'(fifo[c].pop_front());
    end
    if (mdl_busy) begin
      if (exp_valid && m_ready) begin
        mdl_beats++;
        if (mdl_beats == BURST_MAX) begin
          mdl_busy       = 1'b0;
          mdl_last_grant = mdl_id;
          mdl_bursts     = (mdl_bursts + 1) % 65536;
        end
      end
    end else if (enable) begin
      nxt = rr_pick(mdl_last_grant, ch_burst_rdy);
      if (nxt >= 0) begin
        mdl_busy  = 1'b1;
        mdl_id    = nxt;
        mdl_beats = 0;
      end
    end
    cyc++;
    @(negedge pos_rclk);
  endtask

  task automatic apply_reset();
    reset_rclk   = 1'b0;
    enable       = 1'b0;
    ch_burst_rdy = '0;
    m_ready      = 1'b0;
    model_reset();
    clear_env();
    refresh();
    @(posedge pos_rclk);
    @(negedge pos_rclk);
    reset_rclk = 1'b1;
  endtask

  task automatic fill(int c, logic [DWIDTH-1:0] base, int n);
    for (int k = 0; k < n; k++) fifo[c].push_back(base + DWIDTH'(k));
  endtask

  task automatic test_reset();
    reset_rclk   = 1'b0;
    enable       = 1'b0;
    ch_burst_rdy = '0;
    m_ready      = 1'b1;
    model_reset();
    clear_env();
    refresh();
    #1;
    total++; if (busy !== 1'b0) $display("FAIL reset_busy got=%b exp=0", busy); else passed++;
    total++; if (m_valid !== 1'b0) $display("FAIL reset_m_valid got=%b exp=0", m_valid); else passed++;
    total++; if (m_last !== 1'b0) $display("FAIL reset_m_last got=%b exp=0", m_last); else passed++;
    total++; if (ch_rd_en !== '0) $display("FAIL reset_rd_en got=%b exp=0", ch_rd_en); else passed++;
    total++; if (m_id !== '0) $display("FAIL reset_m_id got=%0d exp=0", m_id); else passed++;
    total++; if (burst_cnt !== 16'd0) $display("FAIL reset_burst_cnt got=%0d exp=0", burst_cnt); else passed++;
    @(negedge pos_rclk);
    reset_rclk = 1'b1;
    tick();
  endtask

  task automatic test_single_burst();
    apply_reset();
    fill(1, 64'h10, 4);
    enable = 1'b1; m_ready = 1'b1; ch_burst_rdy = 4'b0010;
    tick();
    ch_burst_rdy = '0;
    repeat (5) tick();
    total++; if (seen.size() !== 4) $display("FAIL single_beats got=%0d exp=4", seen.size()); else passed++;
    if (seen.size() == 4) begin
      for (int i = 0; i < 4; i++) begin
        total++; if (seen[i].data !== 64'h10 + 64'(i)) $display("FAIL single_data beat=%0d got=%h exp=%h", i, seen[i].data, 64'h10 + 64'(i)); else passed++;
        total++; if (seen[i].id !== 1) $display("FAIL single_id beat=%0d got=%0d exp=1", i, seen[i].id); else passed++;
        total++; if (seen[i].last !== (i == 3)) $display("FAIL single_last beat=%0d got=%b exp=%b", i, seen[i].last, (i == 3)); else passed++;
        total++; if (seen[i].cyc !== seen[0].cyc + i) $display("FAIL single_consecutive beat=%0d got=%0d exp=%0d", i, seen[i].cyc, seen[0].cyc + i); else passed++;
      end
    end
    total++; if (pops[1] !== 4 || pops[0] + pops[2] + pops[3] !== 0) $display("FAIL single_pops got=%0d/%0d exp=4/0", pops[1], pops[0] + pops[2] + pops[3]); else passed++;
    total++; if (burst_cnt !== 16'd1) $display("FAIL single_burst_cnt got=%0d exp=1", burst_cnt); else passed++;
  endtask

  task automatic test_all_ready();
    int exp_seq [5] = '{0, 1, 2, 3, 0};
    apply_reset();
    for (int c = 0; c < NUM_CH; c++) fill(c, 64'(c) << 8, 8);
    enable = 1'b1; m_ready = 1'b1; ch_burst_rdy = 4'hF;
    repeat (25) tick();
    ch_burst_rdy = '0;
    tick();
    total++; if (seen.size() !== 20) $display("FAIL rr_beats got=%0d exp=20", seen.size()); else passed++;
    if (seen.size() == 20) begin
      for (int b = 0; b < 5; b++) begin
        total++; if (seen[4*b].id !== exp_seq[b]) $display("FAIL rr_order burst=%0d got=%0d exp=%0d", b, seen[4*b].id, exp_seq[b]); else passed++;
        if (b > 0) begin
          total++; if (seen[4*b].cyc - seen[4*b-1].cyc !== 2) $display("FAIL rr_gap burst=%0d got=%0d exp=2", b, seen[4*b].cyc - seen[4*b-1].cyc); else passed++;
        end
      end
    end
    total++; if (burst_cnt !== 16'd5) $display("FAIL rr_burst_cnt got=%0d exp=5", burst_cnt); else passed++;
  endtask

  task automatic test_ready_toggle();
    apply_reset();
    fill(2, 64'h20, 4);
    enable = 1'b1; m_ready = 1'b0; ch_burst_rdy = 4'b0100;
    tick();
    ch_burst_rdy = '0;
    for (int j = 0; j < 8; j++) begin
      m_ready = (j % 2 == 0);
      tick();
    end
    m_ready = 1'b0;
    tick();
    total++; if (pops[2] !== 4) $display("FAIL toggle_pops got=%0d exp=4", pops[2]); else passed++;
    total++; if (seen.size() !== 4) $display("FAIL toggle_beats got=%0d exp=4", seen.size()); else passed++;
    if (seen.size() == 4) begin
      for (int i = 0; i < 4; i++) begin
        total++; if (seen[i].data !== 64'h20 + 64'(i)) $display("FAIL toggle_data beat=%0d got=%h exp=%h", i, seen[i].data, 64'h20 + 64'(i)); else passed++;
      end
      total++; if (seen[3].cyc - seen[0].cyc !== 6) $display("FAIL toggle_span got=%0d exp=6", seen[3].cyc - seen[0].cyc); else passed++;
    end
  endtask

  task automatic test_empty_stall();
    apply_reset();
    fill(0, 64'h30, 4);
    enable = 1'b1; m_ready = 1'b1; ch_burst_rdy = 4'b0001;
    tick();
    ch_burst_rdy = '0;
    repeat (2) tick();
    force_empty[0] = 1'b1;
    repeat (3) tick();
    force_empty[0] = 1'b0;
    repeat (3) tick();
    total++; if (pops[0] !== 4) $display("FAIL stall_pops got=%0d exp=4", pops[0]); else passed++;
    total++; if (seen.size() !== 4) $display("FAIL stall_beats got=%0d exp=4", seen.size()); else passed++;
    if (seen.size() == 4) begin
      total++; if (seen[2].cyc - seen[1].cyc !== 4) $display("FAIL stall_gap got=%0d exp=4", seen[2].cyc - seen[1].cyc); else passed++;
      total++; if (seen[3].last !== 1'b1 || seen[2].last !== 1'b0) $display("FAIL stall_last got=%b%b exp=10", seen[3].last, seen[2].last); else passed++;
    end
    total++; if (burst_cnt !== 16'd1) $display("FAIL stall_burst_cnt got=%0d exp=1", burst_cnt); else passed++;
  endtask

  task automatic test_enable_drop();
    apply_reset();
    fill(1, 64'h40, 4);
    fill(3, 64'h50, 4);
    enable = 1'b1; m_ready = 1'b1; ch_burst_rdy = 4'b1010;
    repeat (2) tick();
    enable = 1'b0;
    repeat (7) tick();
    total++; if (seen.size() !== 4) $display("FAIL endrop_beats got=%0d exp=4", seen.size()); else passed++;
    for (int i = 0; i < seen.size(); i++) begin
      total++; if (seen[i].id !== 1) $display("FAIL endrop_id beat=%0d got=%0d exp=1", i, seen[i].id); else passed++;
    end
    total++; if (busy !== 1'b0) $display("FAIL endrop_idle got=%b exp=0", busy); else passed++;
    enable = 1'b1;
    repeat (5) tick();
    ch_burst_rdy = '0;
    tick();
    total++; if (seen.size() !== 8) $display("FAIL endrop_resume got=%0d exp=8", seen.size()); else passed++;
    if (seen.size() == 8) begin
      total++; if (seen[4].id !== 3 || seen[7].id !== 3) $display("FAIL endrop_next_id got=%0d exp=3", seen[4].id); else passed++;
    end
    total++; if (burst_cnt !== 16'd2) $display("FAIL endrop_burst_cnt got=%0d exp=2", burst_cnt); else passed++;
  endtask

  task automatic test_reset_mid_burst();
    fill(2, 64'h60, 4);
    enable = 1'b1; m_ready = 1'b1; ch_burst_rdy = 4'b0100;
    tick();
    ch_burst_rdy = '0;
    repeat (2) tick();
    #2;
    reset_rclk = 1'b0;
    #1;
    total++; if (busy !== 1'b0) $display("FAIL midrst_busy got=%b exp=0", busy); else passed++;
    total++; if (m_valid !== 1'b0) $display("FAIL midrst_m_valid got=%b exp=0", m_valid); else passed++;
    total++; if (m_last !== 1'b0) $display("FAIL midrst_m_last got=%b exp=0", m_last); else passed++;
    total++; if (ch_rd_en !== '0) $display("FAIL midrst_rd_en got=%b exp=0", ch_rd_en); else passed++;
    total++; if (m_id !== '0) $display("FAIL midrst_m_id got=%0d exp=0", m_id); else passed++;
    total++; if (burst_cnt !== 16'd0) $display("FAIL midrst_burst_cnt got=%0d exp=0", burst_cnt); else passed++;
    model_reset();
    clear_env();
    @(posedge pos_rclk);
    @(negedge pos_rclk);
    reset_rclk = 1'b1;
    fill(0, 64'h70, 4);
    fill(2, 64'h80, 4);
    ch_burst_rdy = 4'b0101;
    tick();
    ch_burst_rdy = '0;
    repeat (5) tick();
    total++; if (seen.size() !== 4) $display("FAIL midrst_beats got=%0d exp=4", seen.size()); else passed++;
    if (seen.size() == 4) begin
      total++; if (seen[0].id !== 0 || seen[0].data !== 64'h70) $display("FAIL midrst_first_grant got=%0d/%h exp=0/70", seen[0].id, seen[0].data); else passed++;
    end
  endtask

  task automatic test_random();
    apply_reset();
    for (int n = 0; n < 800; n++) begin
      enable       = ($urandom_range(0, 9) != 0);
      ch_burst_rdy = NUM_CH'($urandom);
      m_ready      = ($urandom_range(0, 3) != 0);
      for (int c = 0; c < NUM_CH; c++) begin
        force_empty[c] = ($urandom_range(0, 7) == 0);
        while (fifo[c].size() < 2 * BURST_MAX) begin
          fifo[c].push_back({32'(c), 32'(seq)});
          seq++;
        end
      end
      tick();
    end
    total++; if (burst_cnt !== 16'(mdl_bursts) || mdl_bursts < 20) $display("FAIL random_progress got=%0d exp=%0d (min 20)", burst_cnt, mdl_bursts); else passed++;
  endtask

  initial begin
    test_reset();
    test_single_burst();
    test_all_ready();
    test_ready_toggle();
    test_empty_stall();
    test_enable_drop();
    test_reset_mid_burst();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
